// File: rtl/sw_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sw_cond_pkg
// Description : Shared types and constants for the slide-switch conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package sw_cond_pkg;

    localparam int N_SW_DEFAULT = 4;
    localparam int CHG_CNT_W    = 16;

    typedef enum logic [0:0] {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } sw_state_e;

    function automatic int sw_clog2(input int value);
        int result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce_bit
// Description : One switch bit: 2-FF synchroniser, settle counter and FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce_bit
    import sw_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
)(
    input  logic clk,
    input  logic rst,
    input  logic i_sw_raw,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);

    localparam int             CNT_W      = sw_clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic             r_s1;
    logic             r_s2;
    sw_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             r_rise;
    logic             r_fall;

    sw_state_e        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_stable_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_state  <= ST_STABLE;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_s1     <= i_sw_raw;
            r_s2     <= r_s1;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_stable <= w_stable_nxt;
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_stable_nxt = r_stable;
        w_rise_nxt   = 1'b0;
        w_fall_nxt   = 1'b0;
        case (r_state)
            ST_STABLE: begin
                if (r_s2 != r_stable) begin
                    w_state_nxt = ST_SETTLING;
                    w_cnt_nxt   = c_CNT_ONE;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            ST_SETTLING: begin
                // Any return to the committed level restarts the whole window.
                if (r_s2 == r_stable) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt  = ST_STABLE;
                    w_cnt_nxt    = '0;
                    w_stable_nxt = r_s2;
                    w_rise_nxt   = r_s2;
                    w_fall_nxt   = ~r_s2;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_stable = r_stable;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;

endmodule
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce
// Description : Debounced switch vector with edge pulses and change counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce
    import sw_cond_pkg::*;
#(
    parameter int N_SW            = N_SW_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 500000
)(
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic [N_SW-1:0]      sw_raw,
    output logic [N_SW-1:0]      sw_export,
    output logic [N_SW-1:0]      sw_rise,
    output logic [N_SW-1:0]      sw_fall,
    output logic                 sw_changed,
    output logic [CHG_CNT_W-1:0] change_count
);

    logic [N_SW-1:0]      w_edges;
    logic [CHG_CNT_W-1:0] w_popcount;
    logic [CHG_CNT_W-1:0] r_change_count;

    for (genvar gi = 0; gi < N_SW; gi++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk      (clk_clk),
            .rst      (reset_reset),
            .i_sw_raw (sw_raw[gi]),
            .o_stable (sw_export[gi]),
            .o_rise   (sw_rise[gi]),
            .o_fall   (sw_fall[gi])
        );
    end

    // Pulses are already registered per bit, so this OR stays aligned with them.
    assign w_edges    = sw_rise | sw_fall;
    assign sw_changed = |w_edges;

    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < N_SW; i++) begin
            w_popcount = w_popcount + {{(CHG_CNT_W-1){1'b0}}, w_edges[i]};
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_change_count <= '0;
        end else begin
            r_change_count <= r_change_count + w_popcount;
        end
    end

    assign change_count = r_change_count;

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_debounce
// Description : Directed scoreboard bench for sw_debounce with a short window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_debounce;

    localparam int D = 8;

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] expv;
    } evt_t;

    logic        clk_clk;
    logic        reset_reset;
    logic [3:0]  sw_raw;
    logic [3:0]  sw_export;
    logic [3:0]  sw_rise;
    logic [3:0]  sw_fall;
    logic        sw_changed;
    logic [15:0] change_count;

    int          cyc;
    int          n_checks;
    int          n_pass;
    logic [15:0] model_cnt;
    evt_t        sb[$];

    sw_debounce #(
        .N_SW            (4),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .sw_raw       (sw_raw),
        .sw_export    (sw_export),
        .sw_rise      (sw_rise),
        .sw_fall      (sw_fall),
        .sw_changed   (sw_changed),
        .change_count (change_count)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    initial cyc = 0;
    always @(posedge clk_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    // Called at a negedge: the next posedge captures into s1, commit lands D+1 edges later.
    task automatic push_evt(input logic [3:0] r, input logic [3:0] f, input logic [3:0] e);
        evt_t ev;
        ev.cyc  = cyc + D + 2;
        ev.rise = r;
        ev.fall = f;
        ev.expv = e;
        sb.push_back(ev);
        model_cnt = model_cnt + 16'($countones(r | f));
    endtask

    always @(negedge clk_clk) begin
        evt_t ev;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            check("missed_evt_cycle", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if ((sw_rise | sw_fall) != 4'h0 || sw_changed) begin
            if (sb.size() == 0) begin
                check("spurious_pulse", {sw_changed, sw_fall, sw_rise}, 32'h0);
            end else begin
                ev = sb.pop_front();
                check("evt_cycle",   cyc,        ev.cyc);
                check("evt_rise",    sw_rise,    ev.rise);
                check("evt_fall",    sw_fall,    ev.fall);
                check("evt_export",  sw_export,  ev.expv);
                check("evt_changed", sw_changed, 1'b1);
            end
        end
    end

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        model_cnt   = 16'h0;
        reset_reset = 1'b1;
        sw_raw      = 4'hF;

        // Reset held with all switches high: nothing may move.
        cycles(3);
        for (int i = 0; i < 3; i++) begin
            check("rst_export",  sw_export,    4'h0);
            check("rst_pulses",  {sw_rise, sw_fall, sw_changed}, 9'h0);
            check("rst_count",   change_count, 16'h0);
            cycles(1);
        end
        sw_raw = 4'h0;
        cycles(2);
        reset_reset = 1'b0;
        cycles(5);
        check("post_rst_export", sw_export, 4'h0);

        // Single bit rise.
        sw_raw = 4'h1; push_evt(4'h1, 4'h0, 4'h1);
        cycles(D + 6);
        check("b0_export", sw_export, 4'h1);
        check("b0_count",  change_count, model_cnt);

        // Bit 1 pulse of D-1 cycles is rejected.
        sw_raw = 4'h3;
        cycles(D - 1);
        sw_raw = 4'h1;
        cycles(20);
        check("short_export", sw_export, 4'h1);
        check("short_count",  change_count, model_cnt);

        // Bit 1 pulse of D cycles is accepted, then falls.
        sw_raw = 4'h3; push_evt(4'h2, 4'h0, 4'h3);
        cycles(D);
        sw_raw = 4'h1; push_evt(4'h0, 4'h2, 4'h1);
        cycles(20);
        check("long_export", sw_export, 4'h1);
        check("long_count",  change_count, model_cnt);

        // All bits commit together.
        sw_raw = 4'h0; push_evt(4'h0, 4'h1, 4'h0);
        cycles(20);
        sw_raw = 4'hF; push_evt(4'hF, 4'h0, 4'hF);
        cycles(20);
        check("all_export", sw_export, 4'hF);
        check("all_count",  change_count, model_cnt);

        // Chatter on bit 2, then a final settled high.
        sw_raw = 4'h0; push_evt(4'h0, 4'hF, 4'h0);
        cycles(20);
        for (int i = 0; i < 14; i++) begin
            sw_raw[2] = ~sw_raw[2];
            cycles(3);
        end
        sw_raw = 4'h4; push_evt(4'h4, 4'h0, 4'h4);
        cycles(20);
        check("chat_export", sw_export, 4'h4);
        check("chat_count",  change_count, model_cnt);

        // Counter wrap with a two-bit commit.
        force dut.r_change_count = 16'hFFFE;
        cycles(1);
        release dut.r_change_count;
        model_cnt = 16'hFFFE;
        check("preload_count", change_count, 16'hFFFE);
        sw_raw = 4'h7; push_evt(4'h3, 4'h0, 4'h7);
        cycles(20);
        check("wrap_count",  change_count, 16'h0000);
        check("wrap_export", sw_export, 4'h7);

        // Reset mid-settle with the input dropped: no pulse afterwards.
        sw_raw = 4'h0; push_evt(4'h0, 4'h7, 4'h0);
        cycles(20);
        sw_raw = 4'h1;
        cycles(4);
        reset_reset = 1'b1;
        sw_raw      = 4'h0;
        cycles(3);
        model_cnt = 16'h0;
        check("midrst_export", sw_export, 4'h0);
        check("midrst_count",  change_count, 16'h0);
        reset_reset = 1'b0;
        cycles(20);
        check("midrst_after_export", sw_export, 4'h0);

        // Reset mid-settle with the input held: full window reruns.
        sw_raw = 4'h1;
        cycles(4);
        reset_reset = 1'b1;
        cycles(3);
        check("hold_rst_export", sw_export, 4'h0);
        reset_reset = 1'b0; push_evt(4'h1, 4'h0, 4'h1);
        cycles(20);
        check("hold_export", sw_export, 4'h1);
        check("hold_count",  change_count, model_cnt);

        cycles(2);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
